// File: rtl/sigmoid_logit_bisect_if.sv
// Request/response handshake bundle for sigmoid_logit_bisect.
// master drives requests and takes results; slave is the bisection engine.
interface sigmoid_logit_bisect_if #(
    parameter int W_X = 12,
    parameter int W_Y = 12
);
    logic           in_valid;
    logic           in_ready;
    logic [W_Y-1:0] y_in;
    logic           out_valid;
    logic           out_ready;
    logic [W_X-1:0] x_out;
    logic           err;

    modport master (
        output in_valid, y_in, out_ready,
        input  in_ready, out_valid, x_out, err
    );

    modport slave (
        input  in_valid, y_in, out_ready,
        output in_ready, out_valid, x_out, err
    );
endinterface

// File: rtl/sigmoid_logit_bisect.sv
// Inverse of the piecewise-linear sigmoid: smallest Q4.8 x with s(x) >= y, one bisection step per clock.
// Optional feature macro LOGIT_RANGE_CHECK_EN: y > 1.0 sets err and bypasses the 12-step search.
module sigmoid_logit_bisect #(
    parameter int W_X    = 12,
    parameter int X_FRAC = 8,
    parameter int W_Y    = 12,
    parameter int Y_FRAC = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sigmoid_logit_bisect_if.slave bus
);

    localparam logic [W_Y-1:0] Y_ONE     = W_Y'(1 << Y_FRAC);
    localparam logic [W_X-1:0] X_BIAS    = W_X'(1 << (W_X - 1));
    localparam logic [W_X-1:0] X_MAX     = X_BIAS - W_X'(1);
    localparam logic [W_X-1:0] A_SAT     = W_X'(5 << X_FRAC);
    localparam logic [W_X-1:0] A_KNEE2   = W_X'((19 << X_FRAC) >> 3);
    localparam logic [W_X-1:0] A_KNEE1   = W_X'(1 << X_FRAC);
    localparam logic [3:0]     LAST_STEP = 4'(W_X - 1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t         r_state, w_next;
    logic           r_live;
    logic [W_Y-1:0] r_y;
    logic [W_X-1:0] r_lo, r_hi, r_x;
    logic [3:0]     r_iter;
    logic           r_bad, r_err;

    logic           w_in_ready, w_accept, w_range_bad, w_hit;
    logic [W_X:0]   w_sum;
    logic [W_X-1:0] w_mid, w_lo_nxt, w_hi_nxt;

    // Position p in [0, 2^W_X) encodes x = p - 2^(W_X-1); flipping the MSB converts.
    function automatic logic [W_Y-1:0] sig_pwl(input logic [W_X-1:0] pos);
        logic [W_X-1:0] c, a;
        logic [W_Y-1:0] f;
        c = pos ^ X_BIAS;
        a = c[W_X-1] ? (W_X'(0) - c) : c;
        if (a >= A_SAT)        f = Y_ONE;
        else if (a >= A_KNEE2) f = W_Y'(a >> 3) + W_Y'(864);
        else if (a >= A_KNEE1) f = W_Y'(a >> 1) + W_Y'(640);
        else                   f = W_Y'(a) + W_Y'(512);
        return c[W_X-1] ? (Y_ONE - f) : f;
    endfunction

`ifdef LOGIT_RANGE_CHECK_EN
    assign w_range_bad = (bus.y_in > Y_ONE);
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_accept = bus.in_valid && w_in_ready;

    always_comb begin
        w_sum    = {1'b0, r_lo} + {1'b0, r_hi};
        w_mid    = w_sum[W_X:1];
        w_hit    = (sig_pwl(w_mid) >= r_y);
        w_lo_nxt = w_hit ? r_lo : (w_mid + W_X'(1));
        w_hi_nxt = w_hit ? w_mid : r_hi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)              w_next = SEARCH;
            SEARCH:  if (r_iter == LAST_STEP)   w_next = DONE;
            DONE:    if (bus.out_ready)         w_next = IDLE;
            default:                            w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready    = r_live && (r_state == IDLE);
        bus.in_ready  = w_in_ready;
        bus.out_valid = (r_state == DONE);
        bus.x_out     = r_x;
        bus.err       = r_err;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
            r_y    <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_iter <= '0;
            r_bad  <= 1'b0;
            r_x    <= '0;
            r_err  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                IDLE: if (w_accept) begin
                    r_y    <= bus.y_in;
                    r_lo   <= '0;
                    r_hi   <= '1;
                    r_bad  <= w_range_bad;
                    // Out-of-range requests jump to the final step: result one edge later.
                    r_iter <= w_range_bad ? LAST_STEP : 4'd0;
                end
                SEARCH: begin
                    r_lo   <= w_lo_nxt;
                    r_hi   <= w_hi_nxt;
                    r_iter <= r_iter + 4'd1;
                    if (r_iter == LAST_STEP) begin
                        r_x   <= r_bad ? X_MAX : (w_lo_nxt ^ X_BIAS);
                        r_err <= r_bad;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_logit_bisect.sv
// Self-checking bench for sigmoid_logit_bisect: vector table, scoreboard queue, corner sequences, sweep.
module tb_sigmoid_logit_bisect;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sigmoid_logit_bisect_if bus ();

    sigmoid_logit_bisect dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [11:0] y;
        logic [11:0] x;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [11:0] x;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef LOGIT_RANGE_CHECK_EN
    localparam logic BAD_ERR = 1'b1;
    localparam int   BAD_LAT = 1;
`else
    localparam logic BAD_ERR = 1'b0;
    localparam int   BAD_LAT = 12;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference sigmoid on signed Q4.8 integer c, result Q2.10.
    function automatic int s_ref(input int c);
        int a, f;
        a = (c < 0) ? -c : c;
        if (a >= 1280)     f = 1024;
        else if (a >= 608) f = a / 8 + 864;
        else if (a >= 256) f = a / 2 + 640;
        else               f = a + 512;
        return (c < 0) ? 1024 - f : f;
    endfunction

    function automatic logic [11:0] model(input int y);
        int lo, hi, mid;
        lo = 0;
        hi = 4095;
        for (int k = 0; k < 12; k++) begin
            mid = (lo + hi) / 2;
            if (s_ref(mid - 2048) >= y) hi = mid;
            else                        lo = mid + 1;
        end
        return 12'(lo - 2048);
    endfunction

    task automatic run_req(input logic [11:0] y, input int hold, output logic [11:0] x_got);
        exp_t        e;
        int          lat;
        logic [11:0] x_hold;
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.out_ready = (hold == 0);
        bus.y_in      = y;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (sb.size() == 0) e = '{12'h000, 1'b0, 0};
        else                e = sb.pop_front();
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        check("latency", 32'(lat), 32'(e.lat));
        check("x_out", 32'(bus.x_out), 32'(e.x));
        check("err", 32'(bus.err), 32'(e.err));
        x_got  = bus.x_out;
        x_hold = bus.x_out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.y_in     = 12'($urandom);
            @(posedge clk);
            #1;
            check("hold_x_stable", 32'(bus.x_out), 32'(x_hold));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("after_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("after_hs_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t        vecs[6];
    logic [11:0] xg;
    int          xs;

    initial begin
        vecs[0] = '{12'd512,  12'h000, 1'b0,    12};
        vecs[1] = '{12'd896,  12'h200, 1'b0,    12};
        vecs[2] = '{12'd128,  12'hDFF, 1'b0,    12};
        vecs[3] = '{12'd0,    12'h800, 1'b0,    12};
        vecs[4] = '{12'd1024, 12'h500, 1'b0,    12};
        vecs[5] = '{12'd1100, 12'h7FF, BAD_ERR, BAD_LAT};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.y_in      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x_out", 32'(bus.x_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("release_in_ready_high", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            sb.push_back('{vecs[i].x, vecs[i].err, vecs[i].lat});
            run_req(vecs[i].y, 0, xg);
        end

        // Valid request after an out-of-range one must clear err.
        sb.push_back('{12'h200, 1'b0, 12});
        run_req(12'd896, 0, xg);

        // Stalled consumer with in_valid toggling in DONE.
        sb.push_back('{12'hDFF, 1'b0, 12});
        run_req(12'd128, 5, xg);
        sb.push_back('{12'h000, 1'b0, 12});
        run_req(12'd512, 0, xg);

        // Reset in the middle of a search aborts it.
        @(negedge clk);
        bus.y_in     = 12'd896;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_x_out", 32'(bus.x_out), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort_release_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("abort_idle_out_valid", 32'(bus.out_valid), 32'd0);
        sb.push_back('{12'h000, 1'b0, 12});
        run_req(12'd512, 0, xg);

        // Sweep the valid probability range.
        for (int y = 0; y <= 1024; y++) begin
            sb.push_back('{model(y), 1'b0, 12});
            run_req(12'(y), 0, xg);
            xs = int'($signed(xg));
            check("sweep_s_at_x", 32'(s_ref(xs) >= y), 32'd1);
            if (xg != 12'h800)
                check("sweep_s_below_x", 32'(s_ref(xs - 1) < y), 32'd1);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
